// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter/sequencer sharing one single-port mode-controlled
//   memory between requesters A and B. A granted command is latched and
//   presented to the memory for exactly one cycle. Read data is captured
//   one cycle later. A single-cycle ack (with read data) then goes back to
//   the requester that was granted.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   a_req/a_wr/a_addr/a_wdata  requester A command (held until a_ack)
//   a_ack, a_rdata             A completion pulse and read data
//   b_*                        same as A for requester B
//   mem_w_en, mem_mode         memory enable, mode (0 = write, 1 = read)
//   mem_address, mem_data_in   memory address and write data
//   mem_data_out               registered memory read data
//   a_grant_cnt, b_grant_cnt   saturating grant counters
//                              (only when MEM_PORT_ARB_STATS_EN is defined)
//
// Optional feature macro: MEM_PORT_ARB_STATS_EN

module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_w_en,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_PORT_ARB_STATS_EN
  ,
  output logic [7:0]        a_grant_cnt,
  output logic [7:0]        b_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  // Requester ids used for the grant and the round-robin pointer
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                grant_a_c;
  logic                grant_b_c;

  logic                a_ack_d, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_d, b_rdata_d;
  logic                mem_w_en_d, mem_mode_d;
  logic [ADDR_W-1:0]   mem_address_d;
  logic [DATA_W-1:0]   mem_data_in_d;

  // Next-state and next-output logic; outputs are derived from the state
  // being entered so every output leaves a flop.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    grant_a_c     = 1'b0;
    grant_b_c     = 1'b0;
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    a_rdata_d     = a_rdata;
    b_rdata_d     = b_rdata;
    mem_w_en_d    = 1'b0;
    mem_mode_d    = 1'b0;
    mem_address_d = '0;
    mem_data_in_d = '0;

    case (state_q)
      IDLE: begin
        // On a tie, A wins only when B was served last
        grant_a_c = a_req && (!b_req || (last_q == REQ_B));
        grant_b_c = b_req && !grant_a_c;
        if (grant_a_c || grant_b_c) begin
          gnt_d   = grant_b_c ? REQ_B : REQ_A;
          last_d  = gnt_d;
          wr_d    = grant_b_c ? b_wr    : a_wr;
          addr_d  = grant_b_c ? b_addr  : a_addr;
          wdata_d = grant_b_c ? b_wdata : a_wdata;
          state_d = ACCESS;
          // Memory command for the single ACCESS cycle
          mem_w_en_d    = 1'b1;
          mem_mode_d    = ~wr_d;
          mem_address_d = addr_d;
          mem_data_in_d = wr_d ? wdata_d : '0;
        end
      end

      ACCESS: begin
        if (wr_q) begin
          state_d = ACK;
          a_ack_d = (gnt_q == REQ_A);
          b_ack_d = (gnt_q == REQ_B);
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Memory output is valid in this cycle; hand it to the granted side
        state_d = ACK;
        a_ack_d = (gnt_q == REQ_A);
        b_ack_d = (gnt_q == REQ_B);
        if (gnt_q == REQ_A) begin
          a_rdata_d = mem_data_out;
        end else begin
          b_rdata_d = mem_data_out;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_A;
      last_q      <= REQ_B;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      mem_w_en    <= 1'b0;
      mem_mode    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      a_ack       <= a_ack_d;
      b_ack       <= b_ack_d;
      a_rdata     <= a_rdata_d;
      b_rdata     <= b_rdata_d;
      mem_w_en    <= mem_w_en_d;
      mem_mode    <= mem_mode_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
    end
  end

`ifdef MEM_PORT_ARB_STATS_EN
  // Grant counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (grant_a_c && (a_grant_cnt != '1)) begin
        a_grant_cnt <= a_grant_cnt + 8'd1;
      end
      if (grant_b_c && (b_grant_cnt != '1)) begin
        b_grant_cnt <= b_grant_cnt + 8'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. It includes a behavioural
//   memory, so the arbiter has something to drive. Expected values come from
//   a transaction-level model: a reference memory, a round-robin pointer and
//   the per-requester pending state.

module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_req, a_wr, b_req, b_wr;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_ack, b_ack;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_w_en, mem_mode;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
`ifdef MEM_PORT_ARB_STATS_EN
  logic [7:0]        a_grant_cnt, b_grant_cnt;
`endif

  logic              mem_init;
  logic [DATA_W-1:0] mem_arr [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [11:0]       mem_bus;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;

  assign mem_bus = {mem_w_en, mem_mode, mem_address, mem_data_in};

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_req        (a_req),
    .a_wr         (a_wr),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_ack        (a_ack),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_wr         (b_wr),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_ack        (b_ack),
    .b_rdata      (b_rdata),
    .mem_w_en     (mem_w_en),
    .mem_mode     (mem_mode),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
`ifdef MEM_PORT_ARB_STATS_EN
    ,
    .a_grant_cnt  (a_grant_cnt),
    .b_grant_cnt  (b_grant_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory: write when mode=0, registered read when mode=1
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= '0;
      mem_data_out <= '0;
    end else if (mem_w_en) begin
      if (!mem_mode) mem_arr[mem_address] <= mem_data_in;
      else           mem_data_out <= mem_arr[mem_address];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 5'd3; a_wdata = 5'd9;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if ({a_ack, b_ack, a_rdata, b_rdata, mem_bus} !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h expected 000000", i,
                 {a_ack, b_ack, a_rdata, b_rdata, mem_bus});
      end
    end
    // Tie right after reset: A must win
    b_req = 1'b1; b_wr = 1'b1; b_addr = 5'd4; b_wdata = 5'd7;
    rst = 1'b0; mem_init = 1'b0;
    step();
    n_tests++;
    if ({a_ack, b_ack, mem_bus} !== {2'b00, 1'b1, 1'b0, 5'd3, 5'd9}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %h expected %h", {a_ack, b_ack, mem_bus},
               {2'b00, 1'b1, 1'b0, 5'd3, 5'd9});
    end
    step();
    n_tests++;
    if ({a_ack, b_ack, mem_w_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_a_ack: got %b expected 100", {a_ack, b_ack, mem_w_en});
    end
    a_req = 1'b0; ref_mem[3] = 5'd9;
    step();
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b0, 5'd4, 5'd7}) begin
      n_fail++;
      $display("FAIL reset_b_access: got %h expected %h", mem_bus, {1'b1, 1'b0, 5'd4, 5'd7});
    end
    step();
    n_tests++;
    if ({a_ack, b_ack} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_b_ack: got %b expected 01", {a_ack, b_ack});
    end
    b_req = 1'b0; ref_mem[4] = 5'd7;
    step();
  endtask

  task automatic test_write_read();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 5'd5; a_wdata = 5'd27;
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b0, 5'd5, 5'd27}) begin
      n_fail++;
      $display("FAIL wr_access: got %h expected %h", mem_bus, {1'b1, 1'b0, 5'd5, 5'd27});
    end
    step();
    n_tests++;
    if ({a_ack, mem_w_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ack_latency: got %b expected 10", {a_ack, mem_w_en});
    end
    a_req = 1'b0; ref_mem[5] = 5'd27;
    step();
    n_tests++;
    if (a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse: got %b expected 0", a_ack);
    end
    // Read back; write data must not reach the memory for a read
    a_req = 1'b1; a_wr = 1'b0; a_addr = 5'd5; a_wdata = 5'd13;
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b1, 5'd5, 5'd0}) begin
      n_fail++;
      $display("FAIL rd_access: got %h expected %h", mem_bus, {1'b1, 1'b1, 5'd5, 5'd0});
    end
    step();
    n_tests++;
    if ({a_ack, mem_w_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_capture: got %b expected 00", {a_ack, mem_w_en});
    end
    step();
    n_tests++;
    if ({a_ack, a_rdata} !== {1'b1, ref_mem[5]}) begin
      n_fail++;
      $display("FAIL rd_ack_data: got %h expected %h", {a_ack, a_rdata}, {1'b1, ref_mem[5]});
    end
    a_req = 1'b0;
    step();
    n_tests++;
    if ({a_ack, a_rdata} !== {1'b0, 5'd27}) begin
      n_fail++;
      $display("FAIL rd_hold: got %h expected %h", {a_ack, a_rdata}, {1'b0, 5'd27});
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 5'd8;  a_wdata = 5'd26;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 5'd23; b_wdata = 5'd25;
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b0, 5'd8, 5'd26}) begin
      n_fail++;
      $display("FAIL cont_first_a: got %h expected %h", mem_bus, {1'b1, 1'b0, 5'd8, 5'd26});
    end
    step();
    a_req = 1'b0; ref_mem[8] = 5'd26;
    step();
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b0, 5'd23, 5'd25}) begin
      n_fail++;
      $display("FAIL cont_then_b: got %h expected %h", mem_bus, {1'b1, 1'b0, 5'd23, 5'd25});
    end
    step();
    b_req = 1'b0; ref_mem[23] = 5'd25;
    step();
    // Both read back together: B went last, so A again first
    a_req = 1'b1; a_wr = 1'b0; a_addr = 5'd8;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 5'd23;
    step();
    step();
    step();
    n_tests++;
    if ({a_ack, b_ack, a_rdata} !== {2'b10, 5'd26}) begin
      n_fail++;
      $display("FAIL cont_a_read: got %h expected %h", {a_ack, b_ack, a_rdata}, {2'b10, 5'd26});
    end
    a_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if ({a_ack, b_ack, b_rdata, a_rdata} !== {2'b01, 5'd25, 5'd26}) begin
      n_fail++;
      $display("FAIL cont_b_read: got %h expected %h", {a_ack, b_ack, b_rdata, a_rdata},
               {2'b01, 5'd25, 5'd26});
    end
    b_req = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    int ord [6];
    int got = 0;
    a_req = 1'b1; a_wr = 1'($urandom_range(1)); a_addr = 5'($urandom_range(7));
    a_wdata = 5'($urandom_range(31));
    b_req = 1'b1; b_wr = 1'($urandom_range(1)); b_addr = 5'($urandom_range(7));
    b_wdata = 5'($urandom_range(31));
    for (int c = 0; c < 60 && got < 6; c++) begin
      step();
      if (a_ack || b_ack) begin
        ord[got] = (a_ack && b_ack) ? 2 : (a_ack ? 0 : 1);
        if (a_ack && !a_wr || b_ack && !b_wr && !a_ack) begin
          n_tests++;
          if ((a_ack ? a_rdata : b_rdata) !== ref_mem[a_ack ? a_addr : b_addr]) begin
            n_fail++;
            $display("FAIL fair_rdata[%0d]: got %h expected %h", got,
                     a_ack ? a_rdata : b_rdata, ref_mem[a_ack ? a_addr : b_addr]);
          end
        end else if (a_ack) begin
          ref_mem[a_addr] = a_wdata;
        end else begin
          ref_mem[b_addr] = b_wdata;
        end
        got++;
        if (got < 6) begin
          if (a_ack) begin
            a_wr = 1'($urandom_range(1)); a_addr = 5'($urandom_range(7));
            a_wdata = 5'($urandom_range(31));
          end else begin
            b_wr = 1'($urandom_range(1)); b_addr = 5'($urandom_range(7));
            b_wdata = 5'($urandom_range(31));
          end
        end else begin
          a_req = 1'b0; b_req = 1'b0;
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL fair_count: got %0d acks expected 6", got);
    end
    for (int i = 0; i < got; i++) begin
      n_tests++;
      if (ord[i] != (i % 2)) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: got %0d expected %0d (0=A 1=B)", i, ord[i], i % 2);
      end
    end
    step();
    step();
  endtask

  task automatic test_reset_mid_read();
    a_req = 1'b1; a_wr = 1'b0; a_addr = 5'd8;
    step();
    step();
    rst = 1'b1;
    step();
    n_tests++;
    if ({a_ack, b_ack, a_rdata, b_rdata, mem_bus} !== 24'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h expected 000000",
               {a_ack, b_ack, a_rdata, b_rdata, mem_bus});
    end
    step();
    n_tests++;
    if ({a_ack, mem_w_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_quiet: got %b expected 00", {a_ack, mem_w_en});
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (mem_bus !== {1'b1, 1'b1, 5'd8, 5'd0}) begin
      n_fail++;
      $display("FAIL midrst_regrant: got %h expected %h", mem_bus, {1'b1, 1'b1, 5'd8, 5'd0});
    end
    step();
    step();
    n_tests++;
    if ({a_ack, a_rdata} !== {1'b1, ref_mem[8]}) begin
      n_fail++;
      $display("FAIL midrst_reread: got %h expected %h", {a_ack, a_rdata}, {1'b1, ref_mem[8]});
    end
    a_req = 1'b0;
    step();
  endtask

  // Random traffic from both sides against a transaction-level model
  task automatic test_random();
    localparam int N = 500;
    logic pa = 1'b0, pb = 1'b0, ga = 1'b0, gb = 1'b0;
    int ra = 0, rb = 0, cur = -1, acc_cyc = 0, idle_from, ref_last = 1;
    int n_acc = 0, n_ack = 0, win;
    logic el_a, el_b, prev_wen = 1'b0, cur_wr = 1'b0, stop = 1'b0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] cur_wdata = '0;
    logic [11:0] exp_bus;
    a_req = 1'b0; b_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_from = cyc + 1;
    for (int it = 0; it < N + 8 && !stop; it++) begin
      step();
      el_a = pa && !ga && (ra < cyc);
      el_b = pb && !gb && (rb < cyc);
      if (mem_w_en) begin
        n_tests++;
        n_acc++;
        if (prev_wen || cur >= 0 || cyc < idle_from || !(el_a || el_b)) begin
          n_fail++;
          $display("FAIL rnd_unexpected_access: cycle %0d got bus %h expected no access",
                   cyc, mem_bus);
          stop = 1'b1;
        end else begin
          win = (el_a && el_b) ? (ref_last == 1 ? 0 : 1) : (el_a ? 0 : 1);
          cur_wr    = (win == 0) ? a_wr : b_wr;
          cur_addr  = (win == 0) ? a_addr : b_addr;
          cur_wdata = (win == 0) ? a_wdata : b_wdata;
          exp_bus = {1'b1, ~cur_wr, cur_addr, cur_wr ? cur_wdata : 5'd0};
          if (mem_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL rnd_access: cycle %0d got %h expected %h (winner %0d)",
                     cyc, mem_bus, exp_bus, win);
          end
          cur = win; acc_cyc = cyc; ref_last = win;
          if (win == 0) ga = 1'b1; else gb = 1'b1;
        end
      end else if (cur < 0 && cyc >= idle_from && (el_a || el_b)) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_missed_grant: cycle %0d got no access expected grant", cyc);
        stop = 1'b1;
      end
      if (a_ack || b_ack) begin
        n_tests++;
        n_ack++;
        if (cur < 0 || {a_ack, b_ack} !== {cur == 0, cur == 1} ||
            (cyc - acc_cyc) != (cur_wr ? 1 : 2)) begin
          n_fail++;
          $display("FAIL rnd_ack: cycle %0d got acks %b lat %0d expected owner %0d lat %0d",
                   cyc, {a_ack, b_ack}, cyc - acc_cyc, cur, cur_wr ? 1 : 2);
          stop = 1'b1;
        end else begin
          if (cur_wr) begin
            ref_mem[cur_addr] = cur_wdata;
          end else begin
            n_tests++;
            if ((cur == 0 ? a_rdata : b_rdata) !== ref_mem[cur_addr]) begin
              n_fail++;
              $display("FAIL rnd_rdata: cycle %0d got %h expected %h", cyc,
                       cur == 0 ? a_rdata : b_rdata, ref_mem[cur_addr]);
            end
          end
          if (cur == 0) begin pa = 1'b0; ga = 1'b0; a_req = 1'b0; end
          else          begin pb = 1'b0; gb = 1'b0; b_req = 1'b0; end
          cur = -1;
          idle_from = cyc + 2;
        end
      end else if (cur >= 0 && (cyc - acc_cyc) > 2) begin
        n_tests++;
        n_fail++;
        $display("FAIL rnd_ack_timeout: cycle %0d got no ack expected one", cyc);
        stop = 1'b1;
      end
      prev_wen = mem_w_en;
      // Requester A
      if (!pa && it < N && $urandom_range(2) == 0) begin
        pa = 1'b1; ga = 1'b0; ra = cyc; a_req = 1'b1;
        a_wr = 1'($urandom_range(1)); a_addr = 5'($urandom_range(7));
        a_wdata = 5'($urandom_range(31));
      end else if (pa && !ga) begin
        if (it >= N) begin
          pa = 1'b0; a_req = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          a_wr = 1'($urandom_range(1)); a_addr = 5'($urandom_range(7));
          a_wdata = 5'($urandom_range(31));
        end
      end
      // Requester B
      if (!pb && it < N && $urandom_range(2) == 0) begin
        pb = 1'b1; gb = 1'b0; rb = cyc; b_req = 1'b1;
        b_wr = 1'($urandom_range(1)); b_addr = 5'($urandom_range(7));
        b_wdata = 5'($urandom_range(31));
      end else if (pb && !gb) begin
        if (it >= N) begin
          pb = 1'b0; b_req = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          b_wr = 1'($urandom_range(1)); b_addr = 5'($urandom_range(7));
          b_wdata = 5'($urandom_range(31));
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    n_tests++;
    if (n_acc != n_ack || n_ack < 40) begin
      n_fail++;
      $display("FAIL rnd_totals: got %0d accesses %0d acks expected equal and >= 40",
               n_acc, n_ack);
    end
    step();
    step();
  endtask

`ifdef MEM_PORT_ARB_STATS_EN
  task automatic test_stats();
    int acks = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({a_grant_cnt, b_grant_cnt} !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_reset: got %h expected 0000", {a_grant_cnt, b_grant_cnt});
    end
    a_req = 1'b1; a_wr = 1'b1; a_addr = 5'd0; a_wdata = 5'd17; b_req = 1'b0;
    for (int c = 0; c < 1200 && acks < 300; c++) begin
      step();
      if (a_ack) begin
        acks++;
        if (acks == 10) begin
          n_tests++;
          if (a_grant_cnt !== 8'd10) begin
            n_fail++;
            $display("FAIL stats_count10: got %0d expected 10", a_grant_cnt);
          end
        end
      end
    end
    a_req = 1'b0; ref_mem[0] = 5'd17;
    step();
    n_tests++;
    if ({acks == 300, a_grant_cnt, b_grant_cnt} !== {1'b1, 8'd255, 8'd0}) begin
      n_fail++;
      $display("FAIL stats_saturate: got acks %0d a %0d b %0d expected 300 255 0",
               acks, a_grant_cnt, b_grant_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_fairness();
    test_reset_mid_read();
    test_random();
`ifdef MEM_PORT_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
